// File: rtl/ddr3_mon_pkg.sv
// Shared constants for the DDR3 command monitor: command/error encodings,
// geometry and default timing values.
package ddr3_mon_pkg;

   localparam int unsigned NumBanks = 8;
   localparam int unsigned BankW    = 3;
   localparam int unsigned RowW     = 13;
   localparam int unsigned CntW     = 8;

   localparam int unsigned DefTrcd  = 6;
   localparam int unsigned DefTrp   = 6;
   localparam int unsigned DefTrfc  = 44;

   // Command code is the raw {rasn, casn, wen} pin pattern.
   typedef enum logic [2:0] {
      CmdMrs = 3'd0,
      CmdRef = 3'd1,
      CmdPre = 3'd2,
      CmdAct = 3'd3,
      CmdWr  = 3'd4,
      CmdRd  = 3'd5,
      CmdZq  = 3'd6,
      CmdNop = 3'd7
   } cmd_e;

   typedef enum logic [2:0] {
      ErrNone    = 3'd0,
      ErrActOpen = 3'd1,
      ErrClosed  = 3'd2,
      ErrTrcd    = 3'd3,
      ErrTrp     = 3'd4,
      ErrRefOpen = 3'd5,
      ErrTrfc    = 3'd6
   } err_e;

   typedef enum logic {
      StIdle = 1'b0,
      StOpen = 1'b1
   } bank_state_e;

   // Down-counter step that sticks at zero.
   function automatic logic [CntW-1:0] cnt_next(input logic [CntW-1:0] cnt);
      return (cnt == '0) ? '0 : cnt - CntW'(1);
   endfunction

endpackage

// File: rtl/ddr3_bank_tracker.sv
// Tracks one bank: open/idle state, the active row and the tRCD/tRP timers.
module ddr3_bank_tracker
   import ddr3_mon_pkg::*;
#(
   parameter int unsigned TRCD = DefTrcd,
   parameter int unsigned TRP  = DefTrp
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            hit_i,     // decoded command applies to this bank
   input  cmd_e            cmd_i,
   input  logic            a10_i,
   input  logic [RowW-1:0] row_i,
   output logic            open_o,
   output logic [RowW-1:0] row_o,
   output logic            trcd_busy_o,
   output logic            trp_busy_o
);

   bank_state_e     state_q, state_d;
   logic [RowW-1:0] row_q, row_d;
   logic [CntW-1:0] trcd_q, trcd_d;
   logic [CntW-1:0] trp_q, trp_d;

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         row_q   <= '0;
         trcd_q  <= '0;
         trp_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         trcd_q  <= trcd_d;
         trp_q   <= trp_d;
      end
   end

   // Next state: timers free-run down, commands reload them and move the FSM.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      trcd_d  = cnt_next(trcd_q);
      trp_d   = cnt_next(trp_q);
      if (hit_i) begin
         unique case (cmd_i)
            CmdAct: begin
               state_d = StOpen;
               row_d   = row_i;
               trcd_d  = CntW'(TRCD - 1);
            end
            CmdPre: begin
               state_d = StIdle;
               row_d   = '0;
               trp_d   = CntW'(TRP - 1);
            end
            CmdRd, CmdWr: begin
               // Auto-precharge only acts on a bank that is actually open.
               if (a10_i && (state_q == StOpen)) begin
                  state_d = StIdle;
                  row_d   = '0;
                  trp_d   = CntW'(TRP - 1);
               end
            end
            default: ;
         endcase
      end
   end

   assign open_o      = (state_q == StOpen);
   assign row_o       = row_q;
   assign trcd_busy_o = (trcd_q != '0);
   assign trp_busy_o  = (trp_q != '0);

endmodule

// File: rtl/ddr3_cmd_monitor.sv
// Passive DDR3 command-bus monitor: decodes commands, tracks per-bank state and
// flags protocol/timing violations.
module ddr3_cmd_monitor
   import ddr3_mon_pkg::*;
#(
   parameter int unsigned TRCD = DefTrcd,
   parameter int unsigned TRP  = DefTrp,
   parameter int unsigned TRFC = DefTrfc
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ddr3_cke,
   input  logic         ddr3_csn,
   input  logic         ddr3_rasn,
   input  logic         ddr3_casn,
   input  logic         ddr3_wen,
   input  logic [2:0]   ddr3_ba,
   input  logic [12:0]  ddr3_a,
   output logic         cmd_valid,
   output logic [2:0]   cmd_code,
   output logic [2:0]   cmd_bank,
   output logic [12:0]  cmd_addr,
   output logic [7:0]   bank_open,
   output logic [103:0] open_row,
   output logic         err_valid,
   output logic [2:0]   err_code,
   output logic [15:0]  err_count
);

   cmd_e                cmd;
   logic                issue;
   err_e                err;
   logic [NumBanks-1:0] hit;
   logic [NumBanks-1:0] trcd_busy;
   logic [NumBanks-1:0] trp_busy;

   logic            cmd_valid_q, cmd_valid_d;
   logic [2:0]      cmd_code_q, cmd_code_d;
   logic [2:0]      cmd_bank_q, cmd_bank_d;
   logic [12:0]     cmd_addr_q, cmd_addr_d;
   logic            err_valid_q, err_valid_d;
   logic [2:0]      err_code_q, err_code_d;
   logic [15:0]     err_count_q, err_count_d;
   logic [CntW-1:0] trfc_q, trfc_d;

   assign cmd   = cmd_e'({ddr3_rasn, ddr3_casn, ddr3_wen});
   assign issue = ddr3_cke && !ddr3_csn && (cmd != CmdNop);

   for (genvar i = 0; i < NumBanks; i++) begin : g_bank
      assign hit[i] = issue && ((ddr3_ba == 3'(i)) || ((cmd == CmdPre) && ddr3_a[10]));

      ddr3_bank_tracker #(
         .TRCD (TRCD),
         .TRP  (TRP)
      ) u_tracker (
         .clk         (clk),
         .rst         (rst),
         .hit_i       (hit[i]),
         .cmd_i       (cmd),
         .a10_i       (ddr3_a[10]),
         .row_i       (ddr3_a),
         .open_o      (bank_open[i]),
         .row_o       (open_row[i*RowW +: RowW]),
         .trcd_busy_o (trcd_busy[i]),
         .trp_busy_o  (trp_busy[i])
      );
   end

   // Output and tRFC registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_valid_q <= 1'b0;
         cmd_code_q  <= CmdNop;
         cmd_bank_q  <= '0;
         cmd_addr_q  <= '0;
         err_valid_q <= 1'b0;
         err_code_q  <= ErrNone;
         err_count_q <= '0;
         trfc_q      <= '0;
      end else begin
         cmd_valid_q <= cmd_valid_d;
         cmd_code_q  <= cmd_code_d;
         cmd_bank_q  <= cmd_bank_d;
         cmd_addr_q  <= cmd_addr_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
         err_count_q <= err_count_d;
         trfc_q      <= trfc_d;
      end
   end

   // Error classification against pre-edge state, highest priority first.
   always_comb begin
      err = ErrNone;
      if (issue) begin
         if (trfc_q != '0) begin
            err = ErrTrfc;
         end else if ((cmd == CmdAct) && bank_open[ddr3_ba]) begin
            err = ErrActOpen;
         end else if ((cmd == CmdAct) && trp_busy[ddr3_ba]) begin
            err = ErrTrp;
         end else if ((cmd == CmdRef) && (bank_open != '0)) begin
            err = ErrRefOpen;
         end else if (((cmd == CmdRd) || (cmd == CmdWr)) && !bank_open[ddr3_ba]) begin
            err = ErrClosed;
         end else if (((cmd == CmdRd) || (cmd == CmdWr)) && trcd_busy[ddr3_ba]) begin
            err = ErrTrcd;
         end
      end
   end

   // Next-state for the registered command/error outputs and the tRFC timer.
   always_comb begin
      cmd_valid_d = issue;
      cmd_code_d  = cmd_code_q;
      cmd_bank_d  = cmd_bank_q;
      cmd_addr_d  = cmd_addr_q;
      if (issue) begin
         cmd_code_d = cmd;
         cmd_bank_d = ddr3_ba;
         cmd_addr_d = ddr3_a;
      end
      err_valid_d = (err != ErrNone);
      err_code_d  = err;
      err_count_d = err_count_q;
      if (err_valid_d && (err_count_q != 16'hFFFF)) begin
         err_count_d = err_count_q + 16'd1;
      end
      trfc_d = (issue && (cmd == CmdRef)) ? CntW'(TRFC - 1) : cnt_next(trfc_q);
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd_code  = cmd_code_q;
   assign cmd_bank  = cmd_bank_q;
   assign cmd_addr  = cmd_addr_q;
   assign err_valid = err_valid_q;
   assign err_code  = err_code_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_ddr3_cmd_monitor.sv
// Bench for ddr3_cmd_monitor: directed vector table, randomized traffic against a
// cycle-stamp reference model, and error-counter saturation.
module tb_ddr3_cmd_monitor;

   localparam int TRCD = 6;
   localparam int TRP  = 6;
   localparam int TRFC = 44;

   logic         clk = 1'b0;
   logic         rst;
   logic         ddr3_cke, ddr3_csn, ddr3_rasn, ddr3_casn, ddr3_wen;
   logic [2:0]   ddr3_ba;
   logic [12:0]  ddr3_a;
   logic         cmd_valid;
   logic [2:0]   cmd_code, cmd_bank;
   logic [12:0]  cmd_addr;
   logic [7:0]   bank_open;
   logic [103:0] open_row;
   logic         err_valid;
   logic [2:0]   err_code;
   logic [15:0]  err_count;

   always #5 clk = ~clk;

   ddr3_cmd_monitor #(
      .TRCD (TRCD),
      .TRP  (TRP),
      .TRFC (TRFC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ddr3_cke  (ddr3_cke),
      .ddr3_csn  (ddr3_csn),
      .ddr3_rasn (ddr3_rasn),
      .ddr3_casn (ddr3_casn),
      .ddr3_wen  (ddr3_wen),
      .ddr3_ba   (ddr3_ba),
      .ddr3_a    (ddr3_a),
      .cmd_valid (cmd_valid),
      .cmd_code  (cmd_code),
      .cmd_bank  (cmd_bank),
      .cmd_addr  (cmd_addr),
      .bank_open (bank_open),
      .open_row  (open_row),
      .err_valid (err_valid),
      .err_code  (err_code),
      .err_count (err_count)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: legality from cycle stamps of the last ACT/PRE/REF.
   logic        m_open [8];
   logic [12:0] m_row  [8];
   longint      m_act  [8];
   longint      m_pre  [8];
   longint      m_ref;
   longint      m_cyc = 0;
   logic        m_cv;
   logic [2:0]  m_code, m_bank, m_ec;
   logic [12:0] m_addr;
   logic        m_ev;
   int          m_cnt;

   task automatic check(input string name, input logic [103:0] got, input logic [103:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic model_step(input logic r, input logic sel, input logic [2:0] c,
                             input logic [2:0] b, input logic [12:0] a);
      int   e;
      logic issue;
      logic any_open;
      if (r) begin
         for (int j = 0; j < 8; j++) begin
            m_open[j] = 1'b0;
            m_row[j]  = '0;
            m_act[j]  = -1000000;
            m_pre[j]  = -1000000;
         end
         m_ref = -1000000;
         m_cv = 1'b0; m_code = 3'd7; m_bank = '0; m_addr = '0;
         m_ev = 1'b0; m_ec = '0; m_cnt = 0;
      end else begin
         issue = sel && (c != 3'd7);
         any_open = 1'b0;
         for (int j = 0; j < 8; j++) any_open |= m_open[j];
         e = 0;
         if (issue) begin
            if (m_cyc - m_ref < TRFC) e = 6;
            else if (c == 3'd3 && m_open[b]) e = 1;
            else if (c == 3'd3 && (m_cyc - m_pre[b] < TRP)) e = 4;
            else if (c == 3'd1 && any_open) e = 5;
            else if ((c == 3'd4 || c == 3'd5) && !m_open[b]) e = 2;
            else if ((c == 3'd4 || c == 3'd5) && (m_cyc - m_act[b] < TRCD)) e = 3;
            case (c)
               3'd3: begin m_open[b] = 1'b1; m_row[b] = a; m_act[b] = m_cyc; end
               3'd2: begin
                  for (int j = 0; j < 8; j++) begin
                     if (j == int'(b) || a[10]) begin
                        m_open[j] = 1'b0; m_row[j] = '0; m_pre[j] = m_cyc;
                     end
                  end
               end
               3'd1: m_ref = m_cyc;
               3'd4, 3'd5: begin
                  if (a[10] && m_open[b]) begin
                     m_open[b] = 1'b0; m_row[b] = '0; m_pre[b] = m_cyc;
                  end
               end
               default: ;
            endcase
            m_code = c; m_bank = b; m_addr = a;
         end
         m_cv = issue;
         m_ev = (e != 0);
         m_ec = 3'(e);
         if (m_ev && m_cnt < 65535) m_cnt++;
      end
      m_cyc++;
   endtask

   task automatic check_model();
      logic [7:0]   exp_open;
      logic [103:0] exp_rows;
      for (int j = 0; j < 8; j++) begin
         exp_open[j] = m_open[j];
         exp_rows[j*13 +: 13] = m_row[j];
      end
      check("cmd_valid", cmd_valid, m_cv);
      check("cmd_code", cmd_code, m_code);
      check("cmd_bank", cmd_bank, m_bank);
      check("cmd_addr", cmd_addr, m_addr);
      check("bank_open", bank_open, exp_open);
      check("open_row", open_row, exp_rows);
      check("err_valid", err_valid, m_ev);
      check("err_code", err_code, m_ec);
      check("err_count", err_count, 104'(m_cnt));
   endtask

   // One cycle: drive at negedge, model at posedge, outputs settle by next negedge.
   task automatic drive(input logic r, input logic cke, input logic csn, input logic [2:0] c,
                        input logic [2:0] b, input logic [12:0] a);
      rst = r;
      ddr3_cke = cke;
      ddr3_csn = csn;
      {ddr3_rasn, ddr3_casn, ddr3_wen} = c;
      ddr3_ba = b;
      ddr3_a = a;
      @(posedge clk);
      model_step(r, cke && !csn, c, b, a);
      @(negedge clk);
   endtask

   typedef struct {
      logic        r;
      logic        ds;
      logic [2:0]  c;
      logic [2:0]  b;
      logic [12:0] a;
      logic        cv;
      logic [2:0]  code;
      logic [2:0]  bk;
      logic [7:0]  op;
      logic        ev;
      logic [2:0]  ec;
      logic [15:0] cnt;
   } vec_t;

   function automatic vec_t v(logic r, logic ds, logic [2:0] c, logic [2:0] b, logic [12:0] a,
                              logic cv, logic [2:0] code, logic [2:0] bk, logic [7:0] op,
                              logic ev, logic [2:0] ec, logic [15:0] cnt);
      vec_t t;
      t.r = r; t.ds = ds; t.c = c; t.b = b; t.a = a;
      t.cv = cv; t.code = code; t.bk = bk; t.op = op; t.ev = ev; t.ec = ec; t.cnt = cnt;
      return t;
   endfunction

   vec_t tbl[$];

   initial begin
      // Expected outputs after each vector's sampling edge.
      tbl.push_back(v(1, 0, 7, 0, 0,       0, 7, 0, 8'h00, 0, 0, 0));  // reset values
      tbl.push_back(v(0, 0, 3, 2, 13'h155, 1, 3, 2, 8'h04, 0, 0, 0));  // ACT b2
      for (int i = 0; i < 5; i++) tbl.push_back(v(0, 0, 7, 0, 0, 0, 3, 2, 8'h04, 0, 0, 0));
      tbl.push_back(v(0, 0, 5, 2, 13'h010, 1, 5, 2, 8'h04, 0, 0, 0));  // RD exactly at tRCD
      tbl.push_back(v(0, 0, 3, 0, 13'h0AA, 1, 3, 0, 8'h05, 0, 0, 0));  // ACT b0
      for (int i = 0; i < 2; i++) tbl.push_back(v(0, 0, 7, 0, 0, 0, 3, 0, 8'h05, 0, 0, 0));
      tbl.push_back(v(0, 0, 5, 0, 13'h020, 1, 5, 0, 8'h05, 1, 3, 1));  // RD early: TRCD
      tbl.push_back(v(0, 0, 3, 1, 13'h011, 1, 3, 1, 8'h07, 0, 0, 1));  // ACT b1
      tbl.push_back(v(0, 0, 3, 5, 13'h055, 1, 3, 5, 8'h27, 0, 0, 1));  // ACT b5
      tbl.push_back(v(0, 0, 2, 0, 13'h400, 1, 2, 0, 8'h00, 0, 0, 1));  // PRE all
      tbl.push_back(v(0, 0, 7, 0, 0,       0, 2, 0, 8'h00, 0, 0, 1));
      tbl.push_back(v(0, 0, 3, 1, 13'h012, 1, 3, 1, 8'h02, 1, 4, 2));  // ACT early: TRP
      for (int i = 0; i < 3; i++) tbl.push_back(v(0, 0, 7, 0, 0, 0, 3, 1, 8'h02, 0, 0, 2));
      tbl.push_back(v(0, 0, 3, 3, 13'h033, 1, 3, 3, 8'h0A, 0, 0, 2));  // ACT exactly at tRP
      tbl.push_back(v(0, 0, 1, 0, 0,       1, 1, 0, 8'h0A, 1, 5, 3));  // REF with open
      for (int i = 0; i < 9; i++) tbl.push_back(v(0, 0, 7, 0, 0, 0, 1, 0, 8'h0A, 0, 0, 3));
      tbl.push_back(v(0, 0, 3, 4, 13'h044, 1, 3, 4, 8'h1A, 1, 6, 4));  // ACT inside tRFC
      tbl.push_back(v(1, 0, 7, 0, 0,       0, 7, 0, 8'h00, 0, 0, 0));  // reset
      tbl.push_back(v(0, 0, 3, 7, 13'h077, 1, 3, 7, 8'h80, 0, 0, 0));  // ACT b7
      tbl.push_back(v(1, 0, 3, 6, 13'h066, 0, 7, 0, 8'h00, 0, 0, 0));  // reset drops ACT b6
      tbl.push_back(v(0, 0, 5, 7, 13'h000, 1, 5, 7, 8'h00, 1, 2, 1));  // RD closed bank
      tbl.push_back(v(0, 1, 3, 0, 13'h001, 0, 5, 7, 8'h00, 0, 0, 1));  // deselected ACT

      rst = 1'b1; ddr3_cke = 1'b1; ddr3_csn = 1'b1;
      {ddr3_rasn, ddr3_casn, ddr3_wen} = 3'b111; ddr3_ba = '0; ddr3_a = '0;
      @(negedge clk);

      foreach (tbl[k]) begin
         drive(tbl[k].r, 1'b1, tbl[k].ds, tbl[k].c, tbl[k].b, tbl[k].a);
         check($sformatf("v%0d.cmd_valid", k), cmd_valid, tbl[k].cv);
         check($sformatf("v%0d.cmd_code", k), cmd_code, tbl[k].code);
         check($sformatf("v%0d.cmd_bank", k), cmd_bank, tbl[k].bk);
         check($sformatf("v%0d.bank_open", k), bank_open, tbl[k].op);
         check($sformatf("v%0d.err_valid", k), err_valid, tbl[k].ev);
         check($sformatf("v%0d.err_code", k), err_code, tbl[k].ec);
         check($sformatf("v%0d.err_count", k), err_count, tbl[k].cnt);
      end
      check("open_row.b2_after_table", open_row[2*13 +: 13], 13'h000);

      // Randomized traffic against the model.
      drive(1'b1, 1'b1, 1'b1, 3'd7, 3'd0, 13'd0);
      check_model();
      for (int n = 0; n < 3000; n++) begin
         logic        r, cke, csn;
         logic [2:0]  c;
         logic [12:0] a;
         int          p;
         r   = ($urandom_range(0, 299) == 0);
         p   = $urandom_range(0, 19);
         cke = (p != 0);
         csn = (p == 1);
         p   = $urandom_range(0, 99);
         if (p < 35)      c = 3'd7;
         else if (p < 55) c = 3'd3;
         else if (p < 65) c = 3'd5;
         else if (p < 75) c = 3'd4;
         else if (p < 89) c = 3'd2;
         else if (p < 91) c = 3'd1;
         else if (p < 95) c = 3'd0;
         else             c = 3'd6;
         a = 13'($urandom);
         a[10] = ($urandom_range(0, 9) < 3);
         drive(r, cke, csn, c, 3'($urandom_range(0, 7)), a);
         check_model();
      end

      // Saturation: a CLOSED error on every cycle.
      drive(1'b1, 1'b1, 1'b1, 3'd7, 3'd0, 13'd0);
      check("sat.reset_count", err_count, 16'h0000);
      for (int n = 0; n < 70000; n++) begin
         drive(1'b0, 1'b1, 1'b0, 3'd5, 3'd0, 13'd0);
         if (n == 65533) check("sat.count_fffe", err_count, 16'hFFFE);
         if (n == 65534) check("sat.count_ffff", err_count, 16'hFFFF);
      end
      check("sat.count_hold", err_count, 16'hFFFF);
      check("sat.err_valid", err_valid, 1'b1);
      check("sat.err_code", err_code, 3'd2);
      check("sat.model_count", err_count, 104'(m_cnt));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ddr3_cmd_monitor.md
DDR3_CMD_MONITOR -- requirements
Module: ddr3_cmd_monitor

Interface
REQ-001 Parameter TRCD, default 6: min cycles ACT->RD/WR, same bank.
REQ-002 Parameter TRP, default 6: min cycles PRE->ACT, same bank.
REQ-003 Parameter TRFC, default 44: min cycles REF->any non-NOP command.
REQ-004 clk  in  1  single clock, command bus sampled on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 ddr3_cke, ddr3_csn, ddr3_rasn, ddr3_casn, ddr3_wen  in  1 each  DDR3 command pins.
REQ-007 ddr3_ba  in  3  bank address; ddr3_a  in  13  row/column address, A10 = auto-precharge/all-banks.
REQ-008 cmd_valid  out  1  one-cycle pulse, decoded command present.
REQ-009 cmd_code  out  3  command (encoding REQ-012); cmd_bank out 3; cmd_addr out 13.
REQ-010 bank_open  out  8  per-bank row-open flags; open_row  out  8x13 flattened 104  active row per bank.
REQ-011 err_valid out 1 one-cycle pulse; err_code out 3; err_count out 16 saturating.

Function
REQ-012 Decode when cke=1 and csn=0 from {rasn,casn,wen}: 000 MRS=0, 001 REF=1, 010 PRE=2, 011 ACT=3, 100 WR=4, 101 RD=5, 110 ZQ=6, 111 NOP=7.
REQ-013 csn=1 or cke=0 = deselect: no cmd_valid; timers still advance.
REQ-014 cmd_valid/cmd_code/cmd_bank/cmd_addr registered, 1-cycle latency from sampling edge; NOP does not assert cmd_valid.
REQ-015 Per-bank FSM: IDLE -> ACT -> OPEN; OPEN -> PRE (or RD/WR with A10=1) -> IDLE; bank_open/open_row update on the cycle cmd_valid asserts.
REQ-016 PRE with A10=1 closes all 8 banks and loads all 8 tRP timers.
REQ-017 Per-bank down-counters trcd_cnt (loaded TRCD-1 on ACT) and trp_cnt (loaded TRP-1 on PRE/auto-precharge); global trfc_cnt loaded TRFC-1 on REF; all saturate at 0.
REQ-018 Error codes: 1 ACT_OPEN (ACT to open bank), 2 CLOSED (RD/WR to idle bank), 3 TRCD (RD/WR with trcd_cnt!=0), 4 TRP (ACT with trp_cnt!=0), 5 REF_OPEN (REF with any bank open), 6 TRFC (non-NOP command with trfc_cnt!=0).
REQ-019 Priority when several apply: TRFC > ACT_OPEN > TRP > REF_OPEN > CLOSED > TRCD; one err_valid per command, same cycle as cmd_valid.
REQ-020 Errored commands still update state (ACT_OPEN overwrites open_row; CLOSED RD/WR leaves bank idle).
REQ-021 err_count increments per err_valid, holds at 16'hFFFF.
REQ-022 Simultaneous per-bank counter expiry and new command on same bank: command sees counter value before the edge (0 = legal).

Reset
REQ-023 rst=1: cmd_valid=0, cmd_code=7, cmd_bank=0, cmd_addr=0, bank_open=0, open_row=0, err_valid=0, err_code=0, err_count=0, all timers 0.
REQ-024 rst mid-operation discards in-flight command; first sampled edge after rst deasserts decodes normally.

Structure
REQ-025 Shared package ddr3_mon_pkg holds command and error-code constants and default timing parameters.
REQ-026 One sub-module ddr3_bank_tracker (per-bank FSM, open_row, trcd/trp counters) instantiated 8 times via generate.

Verification
REQ-027 ACT bank2 row 0x155, wait 6, RD bank2 -> cmd_valid code 5 bank 2, bank_open=8'h04, no error.
REQ-028 ACT bank0, RD bank0 3 cycles later -> err_valid, err_code=3, err_count=1.
REQ-029 ACT banks 1 and 5, PRE A10=1, ACT bank1 after 2 cycles -> bank_open=0 after PRE, err_code=4.
REQ-030 ACT bank3, REF -> err_code=5; then ACT bank4 10 cycles after REF -> err_code=6 (priority over others).
REQ-031 Force 70000 errors -> err_count=16'hFFFF, holds.
REQ-032 ACT bank7, assert rst 1 cycle, RD bank7 -> bank_open=0 after reset, err_code=2.
